// File: rtl/k6502_bus_trace_if.sv
// Shared-bus sample and drain-port bundle for the k6502 bus-trace unit.
// slave = the trace unit, master = the CPU bus side plus the draining host.
interface k6502_bus_trace_if #(
  parameter int CNT_W = 32
) ();
  logic [15:0]      a;
  logic [7:0]       d;
  logic             rw;
  logic             sync;
  logic             out_ready;
  logic             out_valid;
  logic [15:0]      out_a;
  logic [7:0]       out_d;
  logic [1:0]       out_type;
  logic [CNT_W-1:0] out_cycle;

  modport slave (
    input  a, d, rw, sync, out_ready,
    output out_valid, out_a, out_d, out_type, out_cycle
  );

  modport master (
    output a, d, rw, sync, out_ready,
    input  out_valid, out_a, out_d, out_type, out_cycle
  );
endinterface

// File: rtl/k6502_bus_trace.sv
// k6502 bus-trace capture: cycle-stamped bus samples queued into a FIFO with a valid/ready drain.
// Optional address-window filter enabled by defining K6502_TRACE_FILTER_EN.
module k6502_bus_trace #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          CNT_W      = 32,
  parameter logic [15:0] HALT_ADDR  = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  k6502_bus_trace_if.slave      bus,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  stop,
`ifdef K6502_TRACE_FILTER_EN
  input  logic [15:0]           flt_lo,
  input  logic [15:0]           flt_hi,
`endif
  output logic [DEPTH_LOG2:0]   level,
  output logic                  running,
  output logic                  halted,
  output logic                  overflow
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef struct packed {
    logic [15:0]      a;
    logic [7:0]       d;
    logic [1:0]       t;
    logic [CNT_W-1:0] c;
  } entry_t;

  localparam int                DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  state_t                state;
  entry_t                mem [DEPTH];
  entry_t                entry;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  valid_q;
  logic                  mode_sel;
  logic                  in_range;
  logic                  halt_hit;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  start_go;
  logic                  stop_go;

  always_comb begin
    mode_sel = 1'b1;
    case (mode)
      2'b00:   mode_sel = bus.rw;
      2'b01:   mode_sel = bus.sync;
      2'b10:   mode_sel = bus.rw | bus.sync;
      default: mode_sel = 1'b1;
    endcase
  end

`ifdef K6502_TRACE_FILTER_EN
  // An inverted window (lo > hi) naturally selects nothing.
  assign in_range = (bus.a >= flt_lo) && (bus.a <= flt_hi);
`else
  assign in_range = 1'b1;
`endif

  assign halt_hit = (state == RUN) && bus.rw && (bus.a == HALT_ADDR);
  assign push     = (state == RUN) && ((mode_sel && in_range) || halt_hit);
  assign pop      = valid_q && bus.out_ready;
  assign start_go = start && !stop && (state != RUN);
  assign stop_go  = stop && (state == RUN);
  // A pop on the same edge frees the head slot, so a full FIFO still accepts.
  assign wr_en    = push && ((level != FULL) || pop);
  assign entry    = {bus.a, bus.d, bus.rw, bus.sync, cnt};

  always_comb begin
    level_next = level;
    case ({wr_en, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Stage p0: entry storage, data only
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  // Stage p0: control, pointers, counter and FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      running  <= 1'b0;
      halted   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
    end else if (start_go) begin
      state    <= RUN;
      running  <= 1'b1;
      halted   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      valid_q  <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
    end else begin
      if (state == RUN) cnt <= cnt + 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
      level   <= level_next;
      valid_q <= (level_next != '0);
      if (stop_go) begin
        state   <= IDLE;
        running <= 1'b0;
      end else if (halt_hit) begin
        state   <= HALTED;
        running <= 1'b0;
        halted  <= 1'b1;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_a     = valid_q ? mem[rd_ptr].a : '0;
  assign bus.out_d     = valid_q ? mem[rd_ptr].d : '0;
  assign bus.out_type  = valid_q ? mem[rd_ptr].t : '0;
  assign bus.out_cycle = valid_q ? mem[rd_ptr].c : '0;
endmodule

// File: tb/tb_k6502_bus_trace.sv
// Self-checking bench for k6502_bus_trace: mode table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_k6502_bus_trace;
  localparam int DL    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic [1:0]  t;
    logic [31:0] c;
  } ent_t;

  typedef struct {
    logic [1:0] mode;
    logic       rw;
    logic       sync;
    int         exp_level;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        start;
  logic        stop;
  logic [DL:0] level;
  logic        running;
  logic        halted;
  logic        overflow;
  logic [15:0] flt_lo = 16'h0000;
  logic [15:0] flt_hi = 16'hFFFF;

  k6502_bus_trace_if #(.CNT_W(32)) bif ();

  k6502_bus_trace #(.DEPTH_LOG2(DL), .CNT_W(32), .HALT_ADDR(16'hDEAD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif),
    .mode     (mode),
    .start    (start),
    .stop     (stop),
`ifdef K6502_TRACE_FILTER_EN
    .flt_lo   (flt_lo),
    .flt_hi   (flt_hi),
`endif
    .level    (level),
    .running  (running),
    .halted   (halted),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  ent_t  q[$];
  int    mst;
  logic [31:0] mcnt;
  bit    movf;
  vec_t  tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mst  = 0;
    mcnt = '0;
    movf = 1'b0;
  endtask

  function automatic bit in_filter(input logic [15:0] addr);
`ifdef K6502_TRACE_FILTER_EN
    return (flt_lo <= addr) && (addr <= flt_hi);
`else
    return (addr == addr);
`endif
  endfunction

  // Reference: state 0 idle, 1 run, 2 halted; q holds captured entries in order.
  task automatic model_step();
    bit   sel = 0;
    bit   halt = 0;
    ent_t e = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (start && !stop && mst != 1) begin
      q.delete();
      mcnt = '0;
      movf = 1'b0;
      mst  = 1;
      return;
    end
    if (mst == 1) begin
      halt = bif.rw && (bif.a == 16'hDEAD);
      case (mode)
        2'd0: sel = bif.rw;
        2'd1: sel = bif.sync;
        2'd2: sel = bif.rw || bif.sync;
        default: sel = 1;
      endcase
      sel = sel && in_filter(bif.a);
      e = '{a: bif.a, d: bif.d, t: {bif.rw, bif.sync}, c: mcnt};
      mcnt = mcnt + 1;
    end
    if (q.size() != 0 && bif.out_ready) void'(q.pop_front());
    if (mst == 1 && (sel || halt)) begin
      if (q.size() < DEPTH) q.push_back(e);
      else movf = 1'b1;
    end
    if (mst == 1) begin
      if (stop) mst = 0;
      else if (halt) mst = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, 64'(bif.out_valid), 64'(q.size() != 0));
    chk({tag, ".level"}, 64'(level), 64'(q.size()));
    chk({tag, ".running"}, 64'(running), 64'(mst == 1));
    chk({tag, ".halted"}, 64'(halted), 64'(mst == 2));
    chk({tag, ".overflow"}, 64'(overflow), 64'(movf));
    if (q.size() != 0) begin
      chk({tag, ".a"}, 64'(bif.out_a), 64'(q[0].a));
      chk({tag, ".d"}, 64'(bif.out_d), 64'(q[0].d));
      chk({tag, ".type"}, 64'(bif.out_type), 64'(q[0].t));
      chk({tag, ".cycle"}, 64'(bif.out_cycle), 64'(q[0].c));
    end
  endtask

  task automatic bus_set(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic sync);
    bif.a = a; bif.d = d; bif.rw = rw; bif.sync = sync;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{2'b00, 1'b0, 1'b0, 0}; tbl[1]  = '{2'b00, 1'b0, 1'b1, 0};
    tbl[2]  = '{2'b00, 1'b1, 1'b0, 1}; tbl[3]  = '{2'b00, 1'b1, 1'b1, 1};
    tbl[4]  = '{2'b01, 1'b0, 1'b0, 0}; tbl[5]  = '{2'b01, 1'b0, 1'b1, 1};
    tbl[6]  = '{2'b01, 1'b1, 1'b0, 0}; tbl[7]  = '{2'b01, 1'b1, 1'b1, 1};
    tbl[8]  = '{2'b10, 1'b0, 1'b0, 0}; tbl[9]  = '{2'b10, 1'b0, 1'b1, 1};
    tbl[10] = '{2'b10, 1'b1, 1'b0, 1}; tbl[11] = '{2'b10, 1'b1, 1'b1, 1};
    tbl[12] = '{2'b11, 1'b0, 1'b0, 1}; tbl[13] = '{2'b11, 1'b0, 1'b1, 1};
    tbl[14] = '{2'b11, 1'b1, 1'b0, 1}; tbl[15] = '{2'b11, 1'b1, 1'b1, 1};

    rst_n = 1'b0; mode = 2'b00; start = 1'b0; stop = 1'b0;
    bus_set(16'h0000, 8'h00, 1'b0, 1'b0);
    bif.out_ready = 1'b0;
    model_reset();
    tick(); tick();
    chk("rst.running", 64'(running), 64'(0));
    chk("rst.halted", 64'(halted), 64'(0));
    chk("rst.level", 64'(level), 64'(0));
    chk("rst.valid", 64'(bif.out_valid), 64'(0));
    chk("rst.overflow", 64'(overflow), 64'(0));
    chk("rst.out_a", 64'(bif.out_a), 64'(0));
    chk("rst.out_cycle", 64'(bif.out_cycle), 64'(0));
    rst_n = 1'b1;
    tick();

    // Mode selection table: one sampled cycle after a fresh start.
    for (int i = 0; i < 16; i++) begin
      do_stop();
      do_start();
      mode = tbl[i].mode;
      bus_set(16'h1234, 8'(i), tbl[i].rw, tbl[i].sync);
      tick();
      bus_set(16'h1234, 8'h00, 1'b0, 1'b0);
      chk($sformatf("tbl%0d.level", i), 64'(level), 64'(tbl[i].exp_level));
      cmp_model($sformatf("tbl%0d", i));
    end

    // T2: two writes separated by three fetches.
    do_stop(); mode = 2'b00; do_start();
    bus_set(16'h0010, 8'hAA, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin bus_set(16'h0100 + 16'(i), 8'h11, 1'b0, 1'b1); tick(); end
    bus_set(16'h0011, 8'hBB, 1'b1, 1'b0); tick();
    bus_set(16'h0200, 8'h00, 1'b0, 1'b0); tick();
    chk("t2.level", 64'(level), 64'(2));
    chk("t2.a0", 64'(bif.out_a), 64'(16'h0010));
    chk("t2.d0", 64'(bif.out_d), 64'(8'hAA));
    chk("t2.type0", 64'(bif.out_type), 64'(2'b10));
    chk("t2.cycle0", 64'(bif.out_cycle), 64'(0));
    bif.out_ready = 1'b1; tick();
    chk("t2.a1", 64'(bif.out_a), 64'(16'h0011));
    chk("t2.d1", 64'(bif.out_d), 64'(8'hBB));
    chk("t2.cycle1", 64'(bif.out_cycle), 64'(4));
    tick();
    chk("t2.empty", 64'(bif.out_valid), 64'(0));
    bif.out_ready = 1'b0;

    // T3: overflow with every-cycle capture, then drain after stopping.
    do_stop(); mode = 2'b11; do_start();
    for (int i = 0; i < 6; i++) begin bus_set(16'(i), 8'(i), 1'b0, 1'b0); tick(); end
    chk("t3.level", 64'(level), 64'(4));
    chk("t3.overflow", 64'(overflow), 64'(1));
    do_stop();
    chk("t3.stopped", 64'(running), 64'(0));
    bif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3.valid%0d", i), 64'(bif.out_valid), 64'(1));
      chk($sformatf("t3.cycle%0d", i), 64'(bif.out_cycle), 64'(i));
      tick();
    end
    chk("t3.drained", 64'(bif.out_valid), 64'(0));
    chk("t3.ovf_sticky", 64'(overflow), 64'(1));
    bif.out_ready = 1'b0;

    // T4: full FIFO with simultaneous push and pop.
    do_start();
    for (int i = 0; i < 4; i++) tick();
    chk("t4.full", 64'(level), 64'(4));
    bif.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t4.level%0d", i), 64'(level), 64'(4));
      chk($sformatf("t4.ovf%0d", i), 64'(overflow), 64'(0));
      chk($sformatf("t4.cycle%0d", i), 64'(bif.out_cycle), 64'(i));
    end
    bif.out_ready = 1'b0;

    // T1: asynchronous reset while running with overflow set.
    tick(); tick();
    chk("t1.pre_ovf", 64'(overflow), 64'(1));
    #2 rst_n = 1'b0; model_reset();
    #1;
    chk("t1.running", 64'(running), 64'(0));
    chk("t1.level", 64'(level), 64'(0));
    chk("t1.valid", 64'(bif.out_valid), 64'(0));
    chk("t1.overflow", 64'(overflow), 64'(0));
    tick();
    rst_n = 1'b1;

    // T5: halt on write to HALT_ADDR, then restart.
    mode = 2'b01; do_start();
    bus_set(16'h0400, 8'h01, 1'b0, 1'b1); tick();
    bus_set(16'hDEAD, 8'h42, 1'b1, 1'b0); tick();
    chk("t5.halted", 64'(halted), 64'(1));
    chk("t5.running", 64'(running), 64'(0));
    chk("t5.level", 64'(level), 64'(2));
    bus_set(16'h0401, 8'h02, 1'b0, 1'b1); tick();
    bus_set(16'hDEAD, 8'h43, 1'b1, 1'b0); tick();
    chk("t5.ignored", 64'(level), 64'(2));
    bif.out_ready = 1'b1; tick(); bif.out_ready = 1'b0;
    chk("t5.a", 64'(bif.out_a), 64'(16'hDEAD));
    chk("t5.d", 64'(bif.out_d), 64'(8'h42));
    chk("t5.type", 64'(bif.out_type), 64'(2'b10));
    chk("t5.cycle", 64'(bif.out_cycle), 64'(1));
    bus_set(16'h0402, 8'h03, 1'b0, 1'b1);
    do_start();
    chk("t5.restart", 64'(running), 64'(1));
    chk("t5.flushed", 64'(level), 64'(0));
    chk("t5.flush_valid", 64'(bif.out_valid), 64'(0));
    tick();
    chk("t5.cycle0", 64'(bif.out_cycle), 64'(0));
    cmp_model("t5");

`ifdef K6502_TRACE_FILTER_EN
    // T6: address window filter.
    do_stop(); mode = 2'b00; flt_lo = 16'h0200; flt_hi = 16'h02FF; do_start();
    bus_set(16'h01FF, 8'h01, 1'b1, 1'b0); tick();
    bus_set(16'h0200, 8'h02, 1'b1, 1'b0); tick();
    bus_set(16'h02FF, 8'h03, 1'b1, 1'b0); tick();
    bus_set(16'h0300, 8'h04, 1'b1, 1'b0); tick();
    bus_set(16'h0000, 8'h00, 1'b0, 1'b0);
    chk("t6.level", 64'(level), 64'(2));
    chk("t6.a0", 64'(bif.out_a), 64'(16'h0200));
    bif.out_ready = 1'b1; tick(); bif.out_ready = 1'b0;
    chk("t6.a1", 64'(bif.out_a), 64'(16'h02FF));
    do_stop(); flt_lo = 16'h0300; flt_hi = 16'h0200; do_start();
    bus_set(16'h0250, 8'h05, 1'b1, 1'b0); tick();
    chk("t6.inverted", 64'(level), 64'(0));
    bus_set(16'hDEAD, 8'h06, 1'b1, 1'b0); tick();
    chk("t6.halt_bypass", 64'(level), 64'(1));
    flt_lo = 16'h0000; flt_hi = 16'hFFFF;
`endif

    // Randomized run against the reference model.
    bus_set(16'h0000, 8'h00, 1'b0, 1'b0);
    do_start();
    for (int i = 0; i < 800; i++) begin
      bif.a = ($urandom_range(0, 15) == 0) ? 16'hDEAD : 16'($urandom_range(0, 16'h03FF));
      bif.d = 8'($urandom);
      bif.rw = 1'($urandom);
      bif.sync = 1'($urandom);
      mode = 2'($urandom);
      bif.out_ready = ($urandom_range(0, 2) != 0);
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 24) == 0);
`ifdef K6502_TRACE_FILTER_EN
      if ($urandom_range(0, 49) == 0) begin
        flt_lo = 16'($urandom_range(0, 16'h03FF));
        flt_hi = 16'($urandom_range(0, 16'h03FF));
      end
`endif
      tick();
      cmp_model("rnd");
    end
    start = 1'b0; stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
